// File: rtl/ms6205_pkg.sv
// ============================================================================
// Module   : ms6205_pkg
// Purpose  : Shared types and constants for the MS6205 display write controller
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ms6205_pkg;

  // Bus sequencer states, one per phase of a character write
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ADDR_SETUP  = 3'd1,
    ST_ADDR_STROBE = 3'd2,
    ST_DATA_SETUP  = 3'd3,
    ST_DATA_STROBE = 3'd4,
    ST_RECOVER     = 3'd5
  } ms6205_state_t;

  // Character written to every position by a clear-screen command
  localparam logic [7:0] CLEAR_CHAR = 8'h20;

  // Number of character positions on the display
  localparam int SCREEN_SIZE = 256;

  // Cycles after the data strobe during which the display may drop ready
  localparam int RECOVER_CYCLES = 2;

endpackage

`default_nettype wire

// File: rtl/ms6205_req_fifo.sv
// ============================================================================
// Module   : ms6205_req_fifo
// Purpose  : Synchronous request FIFO holding {addr, data} character writes
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ms6205_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  // Storage array; contents need no reset because occupancy is tracked separately
  always_ff @(posedge Clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = (r_count == c_cnt_w'(DEPTH));
  assign empty    = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ms6205_ctrl.sv
// ============================================================================
// Module   : ms6205_ctrl
// Purpose  : MS6205 character display write controller: buffers character
//            writes, sequences address/data phases with set-up and strobe
//            timing, honours the display ready line, supports screen clear
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ms6205_ctrl
  import ms6205_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       clear_req,
  output logic       busy,
  output logic [7:0] address,
  output logic [7:0] data,
  output logic       write_addr,
  output logic       write_data,
  input  logic       ready
);

  localparam int c_len_ab  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int c_len_max = (c_len_ab > RECOVER_CYCLES) ? c_len_ab : RECOVER_CYCLES;
  localparam int c_cnt_w   = $clog2(c_len_max + 1);

  ms6205_state_t      r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ready_meta;
  logic               r_ready_s;
  logic               r_clr_pend;
  logic               r_clearing;
  logic [7:0]         r_clr_addr;
  logic [7:0]         r_cur_data;

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [15:0]        w_fifo_q;
  logic               w_clr_active;
  logic [7:0]         w_clr_addr;
  int                 w_phase_len;
  logic               w_phase_done;

  assign w_push       = req_valid & req_ready;
  assign w_clr_active = r_clr_pend | r_clearing;
  // A fresh clear starts at position 0; a running one continues where it left off
  assign w_clr_addr   = r_clearing ? r_clr_addr : 8'd0;
  // Clear has priority, so the FIFO is only drained when no clear work remains
  assign w_pop        = (r_state == ST_IDLE) & r_ready_s & ~w_clr_active & ~w_empty;

  ms6205_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_req_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (w_push),
    .push_data ({req_addr, req_data}),
    .pop       (w_pop),
    .pop_data  (w_fifo_q),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign req_ready = ~w_full;
  assign busy      = (r_state != ST_IDLE) | ~w_empty | w_clr_active;

  // Two-flop synchroniser for the display's asynchronous ready line
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ready_meta <= 1'b0;
      r_ready_s    <= 1'b0;
    end else begin
      r_ready_meta <= ready;
      r_ready_s    <= r_ready_meta;
    end
  end

  // Length of the current phase; IDLE is always a single-cycle decision point
  always_comb begin
    w_phase_len = 1;
    case (r_state)
      ST_ADDR_SETUP,  ST_DATA_SETUP:  w_phase_len = SETUP_CYCLES;
      ST_ADDR_STROBE, ST_DATA_STROBE: w_phase_len = STROBE_CYCLES;
      ST_RECOVER:                     w_phase_len = RECOVER_CYCLES;
      default:                        w_phase_len = 1;
    endcase
  end

  assign w_phase_done = (r_cnt == c_cnt_w'(w_phase_len - 1));

  // Bus sequencer with registered bus outputs, phase counter and clear tracking
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_pend <= 1'b0;
      r_clearing <= 1'b0;
      r_clr_addr <= 8'd0;
      r_cur_data <= 8'd0;
      address    <= 8'd0;
      data       <= 8'd0;
      write_addr <= 1'b0;
      write_data <= 1'b0;
    end else begin
      r_cnt <= w_phase_done ? '0 : r_cnt + c_cnt_w'(1);

      // Repeated pulses are absorbed while a clear is pending or running
      if (clear_req && !w_clr_active) begin
        r_clr_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_ready_s) begin
            if (w_clr_active) begin
              r_state    <= ST_ADDR_SETUP;
              address    <= w_clr_addr;
              r_cur_data <= CLEAR_CHAR;
              r_clr_pend <= 1'b0;
              r_clearing <= 1'b1;
              r_clr_addr <= w_clr_addr + 8'd1;
            end else if (!w_empty) begin
              r_state    <= ST_ADDR_SETUP;
              address    <= w_fifo_q[15:8];
              r_cur_data <= w_fifo_q[7:0];
            end
          end
        end
        ST_ADDR_SETUP: begin
          if (w_phase_done) begin
            r_state    <= ST_ADDR_STROBE;
            write_addr <= 1'b1;
          end
        end
        ST_ADDR_STROBE: begin
          if (w_phase_done) begin
            r_state    <= ST_DATA_SETUP;
            write_addr <= 1'b0;
            data       <= r_cur_data;
          end
        end
        ST_DATA_SETUP: begin
          if (w_phase_done) begin
            r_state    <= ST_DATA_STROBE;
            write_data <= 1'b1;
          end
        end
        ST_DATA_STROBE: begin
          if (w_phase_done) begin
            r_state    <= ST_RECOVER;
            write_data <= 1'b0;
          end
        end
        ST_RECOVER: begin
          if (w_phase_done) begin
            r_state <= ST_IDLE;
            // The clear finishes only once its last position has fully completed
            if (r_clearing && address == 8'(SCREEN_SIZE - 1)) begin
              r_clearing <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          write_addr <= 1'b0;
          write_data <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ms6205_ctrl.sv
// ============================================================================
// Module   : tb_ms6205_ctrl
// Purpose  : Self-checking bench for ms6205_ctrl: per-cycle vector table for
//            single writes, directed multi-cycle sequences, and a randomised
//            run against a queue-based reference of the expected bus writes
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ms6205_ctrl;

  localparam int SETUP   = 1;
  localparam int STROBE  = 2;
  localparam int CHAR_CY = 1 + 2*SETUP + 2*STROBE + 2;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_addr = 8'd0;
  logic [7:0] req_data = 8'd0;
  logic       clear_req = 1'b0;
  logic       ready = 1'b0;
  logic       req_ready;
  logic       busy;
  logic [7:0] address;
  logic [7:0] data;
  logic       write_addr;
  logic       write_data;

  ms6205_ctrl #(
    .FIFO_DEPTH    (4),
    .SETUP_CYCLES  (SETUP),
    .STROBE_CYCLES (STROBE)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .clear_req  (clear_req),
    .busy       (busy),
    .address    (address),
    .data       (data),
    .write_addr (write_addr),
    .write_data (write_data),
    .ready      (ready)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t        obs[$];
  wr_t        expq[$];
  int         n_wa = 0;
  int         strobe_err = 0;
  logic       pwa = 1'b0;
  logic       pwd = 1'b0;
  logic [7:0] cap_a = 8'd0;
  int         cap_c = 0;

  // Bus monitor: logs each completed write as seen by the display
  always @(posedge Clk) begin
    #1;
    if (write_addr && write_data) strobe_err++;
    if (write_addr && !pwa) begin
      n_wa++;
      cap_a = address;
      cap_c = cyc;
    end
    if (write_data && !pwd) begin
      obs.push_back('{cap_a, data, cap_c});
      if (address != cap_a) strobe_err++;
    end
    pwa = write_addr;
    pwd = write_data;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_wa(input int target, input int max, input string nm);
    int k = 0;
    while (n_wa < target && k < max) begin
      tick();
      k++;
    end
    chk(nm, n_wa, target);
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    int k = 0;
    @(negedge Clk);
    while (!req_ready && k < 100) begin
      @(negedge Clk);
      k++;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(posedge Clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
  endtask

  // Expected writes for a full-screen clear
  task automatic model_clear();
    for (int i = 0; i < 256; i++) expq.push_back('{8'(i), 8'h20, 0});
  endtask

  task automatic compare_obs(input string nm, input logic chk_each);
    int bad = 0;
    chk({nm, "_count"}, obs.size(), expq.size());
    for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
      if (chk_each) begin
        chk({nm, "_addr"}, obs[i].a, expq[i].a);
        chk({nm, "_data"}, obs[i].d, expq[i].d);
      end else if (obs[i].a !== expq[i].a || obs[i].d !== expq[i].d) begin
        bad++;
      end
    end
    if (!chk_each) chk({nm, "_content_errors"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         wa_first;
    int         wa_last;
    int         wd_first;
    int         wd_last;
    int         idle_at;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [7:0] prev_a;
    logic [7:0] prev_d;
    int         acc;
    int         base;
    int         t0;

    vt[0] = '{8'h12, 8'h41, 3, 4, 6, 7, 10};
    vt[1] = '{8'h00, 8'hFF, 3, 4, 6, 7, 10};
    vt[2] = '{8'hFF, 8'h00, 3, 4, 6, 7, 10};
    vt[3] = '{8'hA5, 8'h5A, 3, 4, 6, 7, 10};
    vt[4] = '{8'h7E, 8'h81, 3, 4, 6, 7, 10};

    // Reset values
    ready = 1'b1;
    repeat (3) tick();
    chk("rst_in_write_addr", {31'd0, write_addr}, 32'd0);
    chk("rst_in_busy", {31'd0, busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_address", address, 8'h00);
    chk("rst_data", data, 8'h00);
    chk("rst_write_addr", {31'd0, write_addr}, 32'd0);
    chk("rst_write_data", {31'd0, write_data}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Per-cycle trace of single writes, cycle 0 being the accept cycle
    prev_a = 8'h00;
    prev_d = 8'h00;
    for (int v = 0; v < 5; v++) begin
      @(negedge Clk);
      req_valid = 1'b1;
      req_addr  = vt[v].a;
      req_data  = vt[v].d;
      @(posedge Clk);
      #2 req_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
        chk($sformatf("v%0d_c%0d_write_addr", v, c), {31'd0, write_addr},
            32'((c >= vt[v].wa_first) && (c <= vt[v].wa_last)));
        chk($sformatf("v%0d_c%0d_write_data", v, c), {31'd0, write_data},
            32'((c >= vt[v].wd_first) && (c <= vt[v].wd_last)));
        chk($sformatf("v%0d_c%0d_busy", v, c), {31'd0, busy}, 32'(c < vt[v].idle_at));
        chk($sformatf("v%0d_c%0d_address", v, c), address, (c >= 2) ? vt[v].a : prev_a);
        chk($sformatf("v%0d_c%0d_data", v, c), data, (c >= 5) ? vt[v].d : prev_d);
        tick();
      end
      prev_a = vt[v].a;
      prev_d = vt[v].d;
    end

    // Back-pressure with the display not ready
    @(negedge Clk);
    ready = 1'b0;
    repeat (4) tick();
    obs.delete();
    expq.delete();
    base = n_wa;
    acc  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      chk($sformatf("bp_req_ready_%0d", i), {31'd0, req_ready}, 32'(i < 4));
      req_valid = 1'b1;
      req_addr  = 8'h30 + 8'(i);
      req_data  = 8'h60 + 8'(i);
      if (req_ready) begin
        acc++;
        expq.push_back('{req_addr, req_data, 0});
      end
      @(posedge Clk);
    end
    #1 req_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    repeat (6) tick();
    chk("bp_no_strobe", n_wa, base);
    chk("bp_busy_stalled", {31'd0, busy}, 32'd1);
    @(negedge Clk);
    ready = 1'b1;
    wait_idle(200, "bp_drain_timeout");
    compare_obs("bp", 1'b1);

    // Ready drops during the first of two writes
    obs.delete();
    expq.delete();
    base = n_wa;
    push(8'h21, 8'h61);
    push(8'h22, 8'h62);
    expq.push_back('{8'h21, 8'h61, 0});
    expq.push_back('{8'h22, 8'h62, 0});
    wait_wa(base + 1, 30, "stall_first_start");
    @(negedge Clk);
    ready = 1'b0;
    repeat (15) tick();
    chk("stall_no_second", n_wa, base + 1);
    @(negedge Clk);
    ready = 1'b1;
    t0 = cyc;
    wait_wa(base + 2, 30, "stall_second_start");
    chk("stall_resume_cycle", cap_c, t0 + 2 + 1 + SETUP);
    wait_idle(50, "stall_idle_timeout");
    compare_obs("stall", 1'b1);

    // Clear issued during a write, with a request queued behind it
    obs.delete();
    expq.delete();
    base = n_wa;
    push(8'h33, 8'h44);
    expq.push_back('{8'h33, 8'h44, 0});
    wait_wa(base + 1, 30, "clr_first_start");
    pulse_clear();
    push(8'h05, 8'h58);
    model_clear();
    expq.push_back('{8'h05, 8'h58, 0});
    wait_idle(3000, "clr_timeout");
    compare_obs("clr", 1'b0);
    if (obs.size() == 258) begin
      chk("clr_first_gap", obs[1].c - obs[0].c, CHAR_CY);
      chk("clr_total_cycles", obs[257].c - obs[1].c, 256 * CHAR_CY);
    end

    // Reset in the middle of the address strobe
    obs.delete();
    base = n_wa;
    push(8'h12, 8'h34);
    wait_wa(base + 1, 30, "rst_mid_start");
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_mid_write_addr", {31'd0, write_addr}, 32'd0);
    chk("rst_mid_write_data", {31'd0, write_data}, 32'd0);
    chk("rst_mid_address", address, 8'h00);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    #2;
    chk("rst_rel_address", address, 8'h00);
    chk("rst_rel_data", data, 8'h00);
    chk("rst_rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rel_busy", {31'd0, busy}, 32'd0);
    base = n_wa;
    repeat (20) tick();
    chk("rst_rel_no_write", n_wa, base);
    chk("rst_rel_no_data", obs.size(), 0);

    // Two clear pulses ten cycles apart yield a single clear
    obs.delete();
    expq.delete();
    model_clear();
    pulse_clear();
    repeat (9) @(negedge Clk);
    clear_req = 1'b1;
    @(negedge Clk);
    clear_req = 1'b0;
    wait_idle(3000, "dclr_timeout");
    repeat (40) tick();
    compare_obs("dclr", 1'b0);

    // Randomised pushes with a randomly toggling ready line
    obs.delete();
    expq.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      if ($urandom_range(0, 5) == 0) ready = ~ready;
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 8'($urandom);
      req_data  = 8'($urandom);
      if (req_valid && req_ready) expq.push_back('{req_addr, req_data, 0});
    end
    @(negedge Clk);
    req_valid = 1'b0;
    ready = 1'b1;
    wait_idle(500, "rnd_drain_timeout");
    compare_obs("rnd", 1'b1);

    chk("one_strobe_and_addr_hold", strobe_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
